// File: rtl/fsk_div_ctrl_if.sv
// Bit handshake, carrier feedback and divider-select bundle for fsk_div_ctrl.
interface fsk_div_ctrl_if;
    logic       en;
    logic       bit_in;
    logic       bit_valid;
    logic       bit_ready;
    logic       car_in;
    logic [3:0] sw_out;
    logic       busy;
    logic       sym_strobe;
    logic       underrun;

    modport master (
        output en, bit_in, bit_valid, car_in,
        input  bit_ready, sw_out, busy, sym_strobe, underrun
    );

    modport slave (
        input  en, bit_in, bit_valid, car_in,
        output bit_ready, sw_out, busy, sym_strobe, underrun
    );
endinterface

// File: rtl/fsk_div_ctrl.sv
// FSK divider-select controller: one symbol per SYM_CYC clocks, with
// phase-aligned switching of the one-hot divide ratio on a carrier edge.
module fsk_div_ctrl #(
    parameter int         SYM_CYC   = 256,
    parameter logic [3:0] F0_SEL    = 4'b0001,
    parameter logic [3:0] F1_SEL    = 4'b0100,
    parameter int         ALIGN_MAX = 32
) (
    input logic          clk_in,
    input logic          rst_n,
    fsk_div_ctrl_if.slave bus
);

    localparam int CW = $clog2(SYM_CYC);
    localparam int AW = $clog2(ALIGN_MAX + 1);
    localparam logic [CW-1:0] CNT_LD   = CW'(SYM_CYC - 1);
    localparam logic [AW-1:0] ALN_LAST = AW'(ALIGN_MAX - 1);

    typedef enum logic [1:0] {IDLE, SEND, ALIGN} state_e;

    state_e        state_q, state_d;
    logic [3:0]    sw_q, sw_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] acnt_q, acnt_d;
    logic          buf_vld_q, buf_vld_d;
    logic          buf_bit_q, buf_bit_d;
    logic          car_q;

    logic ready, hs, last, nxt_vld, nxt_bit, car_rise;
    logic strobe, urun;

    function automatic logic [3:0] sel(input logic b);
        return b ? F1_SEL : F0_SEL;
    endfunction

    // Reset also masks bit_ready so no handshake is advertised while held.
    assign ready    = rst_n & bus.en & ~buf_vld_q & (state_q != ALIGN);
    assign hs       = bus.bit_valid & ready;
    assign last     = (state_q == SEND) && (cnt_q == '0);
    assign nxt_vld  = buf_vld_q | hs;
    assign nxt_bit  = buf_vld_q ? buf_bit_q : bus.bit_in;
    assign car_rise = bus.car_in & ~car_q;

    always_comb begin
        state_d   = state_q;
        sw_d      = sw_q;
        cnt_d     = cnt_q;
        acnt_d    = acnt_q;
        buf_vld_d = buf_vld_q;
        buf_bit_d = buf_bit_q;
        strobe    = 1'b0;
        urun      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (hs) begin
                    state_d = SEND;
                    sw_d    = sel(bus.bit_in);
                    cnt_d   = CNT_LD;
                end
            end
            SEND: begin
                if (!last) begin
                    cnt_d = cnt_q - 1'b1;
                    if (hs) begin
                        buf_vld_d = 1'b1;
                        buf_bit_d = bus.bit_in;
                    end
                end else begin
                    strobe = 1'b1;
                    if (!bus.en) begin
                        state_d   = IDLE;
                        sw_d      = '0;
                        buf_vld_d = 1'b0;
                    end else if (!nxt_vld) begin
                        urun    = 1'b1;
                        state_d = IDLE;
                        sw_d    = '0;
                    end else if (sel(nxt_bit) == sw_q) begin
                        cnt_d     = CNT_LD;
                        buf_vld_d = 1'b0;
                    end else begin
                        state_d   = ALIGN;
                        acnt_d    = '0;
                        buf_vld_d = 1'b1;
                        buf_bit_d = nxt_bit;
                    end
                end
            end
            ALIGN: begin
                if (!bus.en) begin
                    state_d   = IDLE;
                    sw_d      = '0;
                    buf_vld_d = 1'b0;
                end else if (car_rise || acnt_q == ALN_LAST) begin
                    state_d   = SEND;
                    sw_d      = sel(buf_bit_q);
                    buf_vld_d = 1'b0;
                    cnt_d     = CNT_LD;
                end else begin
                    acnt_d = acnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sw_q      <= '0;
            cnt_q     <= '0;
            acnt_q    <= '0;
            buf_vld_q <= 1'b0;
            buf_bit_q <= 1'b0;
            car_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sw_q      <= sw_d;
            cnt_q     <= cnt_d;
            acnt_q    <= acnt_d;
            buf_vld_q <= buf_vld_d;
            buf_bit_q <= buf_bit_d;
            car_q     <= bus.car_in;
        end
    end

    assign bus.bit_ready  = ready;
    assign bus.sw_out     = sw_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.sym_strobe = strobe;
    assign bus.underrun   = urun;

endmodule

// File: tb/tb_fsk_div_ctrl.sv
// Self-checking bench for fsk_div_ctrl: vector table, corner sequences,
// and randomized traffic against a symbol-level reference model.
module tb_fsk_div_ctrl;

  localparam int SC = 16;
  localparam int AM = 32;
  localparam logic [3:0] F0 = 4'b0001;
  localparam logic [3:0] F1 = 4'b0100;
  localparam bit H = 1'b1;
  localparam bit L = 1'b0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  fsk_div_ctrl_if bus();

  fsk_div_ctrl #(
    .SYM_CYC(SC), .F0_SEL(F0), .F1_SEL(F1), .ALIGN_MAX(AM)
  ) u_dut (
    .clk_in(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;

  // reference model: mode 0 idle, 1 sending, 2 waiting for carrier
  int m_mode;
  logic [3:0] m_sw;
  int m_left;
  bit q[$];
  int m_wait;
  bit m_carp;

  logic o_ready, o_busy, o_strobe, o_ur;
  logic [3:0] o_sw;
  bit o_hs;

  typedef struct {
    bit en, bv, bi, car;
    bit ready, busy, strobe, ur;
    logic [3:0] sw;
  } vec_t;

  vec_t tbl[18];

  function automatic logic [3:0] sel(bit b);
    return b ? F1 : F0;
  endfunction

  function automatic vec_t mk(bit en, bit bv, bit bi, bit car, bit rdy,
                              bit bsy, bit stb, bit ur, logic [3:0] sw);
    vec_t v;
    v.en = en; v.bv = bv; v.bi = bi; v.car = car;
    v.ready = rdy; v.busy = bsy; v.strobe = stb; v.ur = ur; v.sw = sw;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_sw = 4'b0; m_left = 0; q.delete(); m_wait = 0; m_carp = 0;
  endtask

  // one clock: drive at posedge+1, sample at posedge+2, advance model
  task automatic cyc(bit en, bit bv, bit bi, bit car);
    bit e_ready, e_strobe, e_hs, e_ur;
    bus.en = en; bus.bit_valid = bv; bus.bit_in = bi; bus.car_in = car;
    #1;
    o_ready = bus.bit_ready; o_busy = bus.busy; o_sw = bus.sw_out;
    o_strobe = bus.sym_strobe; o_ur = bus.underrun;
    o_hs = bv && o_ready;
    e_ready = en && q.size() == 0 && m_mode != 2;
    e_strobe = m_mode == 1 && m_left == 1;
    e_hs = bv && e_ready;
    e_ur = e_strobe && en && q.size() == 0 && !e_hs;
    check("model", {o_ready, o_busy, o_strobe, o_ur, o_sw},
          {e_ready, m_mode != 0, e_strobe, e_ur, m_sw});
    check("onehot", {31'b0, (o_sw == 4'b0 || o_sw == F0 || o_sw == F1)}, 1);
    case (m_mode)
      0: if (e_hs) begin m_mode = 1; m_sw = sel(bi); m_left = SC; end
      1: begin
        if (e_hs) q.push_back(bi);
        if (m_left > 1) m_left--;
        else if (!en) begin m_mode = 0; m_sw = 4'b0; q.delete(); end
        else if (q.size() == 0) begin m_mode = 0; m_sw = 4'b0; end
        else if (sel(q[0]) == m_sw) begin void'(q.pop_front()); m_left = SC; end
        else begin m_mode = 2; m_wait = 0; end
      end
      default: begin
        m_wait++;
        if (!en) begin m_mode = 0; m_sw = 4'b0; q.delete(); end
        else if ((car && !m_carp) || m_wait == AM) begin
          m_sw = sel(q.pop_front()); m_left = SC; m_mode = 1;
        end
      end
    endcase
    m_carp = car;
    @(posedge clk); #1;
  endtask

  // asynchronous reset between clock edges, outputs checked before any edge
  task automatic do_reset();
    bus.en = 1'b1; bus.bit_valid = 1'b1; bus.bit_in = 1'b0; bus.car_in = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("reset", {bus.bit_ready, bus.busy, bus.sym_strobe, bus.underrun, bus.sw_out}, 0);
    model_reset();
    @(posedge clk); #1;
    bus.bit_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic seq_stream();
    int hs_n, run, maxrun, nstr, last_s, gap_bad;
    hs_n = 0; run = 0; maxrun = 0; nstr = 0; last_s = -1; gap_bad = 0;
    do_reset();
    for (int k = 0; k < 70; k++) begin
      cyc(H, hs_n < 3, L, L);
      if (o_hs) hs_n++;
      run = (o_sw == F0) ? run + 1 : 0;
      if (run > maxrun) maxrun = run;
      if (o_strobe) begin
        if (last_s >= 0 && k - last_s != SC) gap_bad++;
        last_s = k;
        nstr++;
      end
    end
    check("stream_run", maxrun, 48);
    check("stream_strobes", nstr, 3);
    check("stream_gap", gap_bad, 0);
  endtask

  task automatic seq_align(bit use_edge);
    int sw_at, len, guard;
    bit found;
    sw_at = -1; len = 0; found = 0;
    do_reset();
    cyc(H, H, L, L);
    cyc(H, H, H, L);
    for (guard = 0; guard < 40 && !found; guard++) begin
      cyc(H, L, L, L);
      if (o_strobe) found = 1;
    end
    check(use_edge ? "edge_strobe_seen" : "tmo_strobe_seen", {31'b0, found}, 1);
    for (int r = 1; r <= 60; r++) begin
      cyc(H, L, L, use_edge && r >= 5);
      if (o_sw == F1) begin
        len++;
        if (sw_at < 0) sw_at = r;
      end
    end
    if (use_edge) check("edge_switch_cycle", sw_at, 6);
    else check("tmo_switch_cycle", sw_at, AM + 1);
    check(use_edge ? "edge_sym_len" : "tmo_sym_len", len, SC);
  endtask

  task automatic seq_en_drop();
    bit any_ur;
    any_ur = 0;
    do_reset();
    cyc(H, H, L, L);
    cyc(H, H, H, L);
    for (int k = 2; k <= 20; k++) begin
      cyc(k < 8, L, L, L);
      if (o_ur) any_ur = 1;
      if (k == 16) check("endrop_strobe", {o_strobe, o_ur}, 2'b10);
      if (k == 17) check("endrop_idle", {o_sw, o_busy, o_ready}, 6'b0);
    end
    check("endrop_no_underrun", {31'b0, any_ur}, 0);
  endtask

  task automatic seq_reset_mid();
    do_reset();
    cyc(H, H, H, L);
    cyc(H, H, L, L);
    for (int k = 0; k < 5; k++) cyc(H, L, L, L);
    do_reset();
    cyc(H, H, L, L);
    check("rstmid_hs", {31'b0, o_hs}, 1);
    cyc(H, L, L, L);
    check("rstmid_sw", o_sw, F0);
    for (int k = 0; k < 20; k++) cyc(H, L, L, L);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit en, bv, bi, car;
    bus.en = 1'b0; bus.bit_valid = 1'b0; bus.bit_in = 1'b0; bus.car_in = 1'b0;
    model_reset();
    tbl[0] = mk(H, H, H, L, H, L, L, L, 4'b0000);
    for (int k = 1; k < 16; k++) tbl[k] = mk(H, L, L, L, H, H, L, L, F1);
    tbl[16] = mk(H, L, L, L, H, H, H, H, F1);
    tbl[17] = mk(H, L, L, L, H, L, L, L, 4'b0000);
    @(posedge clk); #1;

    do_reset();
    foreach (tbl[i]) begin
      cyc(tbl[i].en, tbl[i].bv, tbl[i].bi, tbl[i].car);
      check($sformatf("vec%0d", i), {o_ready, o_busy, o_strobe, o_ur, o_sw},
            {tbl[i].ready, tbl[i].busy, tbl[i].strobe, tbl[i].ur, tbl[i].sw});
    end

    seq_stream();
    seq_align(1'b1);
    seq_align(1'b0);
    seq_en_drop();
    seq_reset_mid();

    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if (i % 1000 == 999) do_reset();
      en = $urandom_range(0, 19) != 0;
      bv = $urandom_range(0, 1) == 1;
      bi = $urandom_range(0, 1) == 1;
      car = ((i / 500) % 2 == 1) ? ($urandom_range(0, 9) == 0) : 1'b0;
      cyc(en, bv, bi, car);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fsk_div_ctrl.md
FSK_DIV_CTRL -- requirements
Module: fsk_div_ctrl

Interface
REQ-001 SHALL have parameter SYM_CYC, default 256: clk_in cycles per symbol (range 2..4096).
REQ-002 SHALL have parameter F0_SEL, default 4'b0001: one-hot divider select for bit 0 (divide-by-32).
REQ-003 SHALL have parameter F1_SEL, default 4'b0100: one-hot divider select for bit 1 (divide-by-8).
REQ-004 SHALL have parameter ALIGN_MAX, default 32: maximum clk_in cycles spent waiting for a carrier edge.
REQ-005 clk_in  in  1  single system clock; all logic on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 en  in  1  modulation enable.
REQ-008 bit_in  in  1  next data bit.
REQ-009 bit_valid  in  1  bit_in valid.
REQ-010 bit_ready  out  1  block accepts bit_in this cycle.
REQ-011 car_in  in  1  carrier fed back from the divider output (clk_in domain).
REQ-012 sw_out  out  4  one-hot divide-ratio select driving the divider; 4'b0000 = carrier halted.
REQ-013 busy  out  1  high in SEND and ALIGN.
REQ-014 sym_strobe  out  1  one-cycle pulse on the last cycle of every symbol.
REQ-015 underrun  out  1  one-cycle pulse when a symbol ends with no next bit while en=1.

Function
REQ-016 SHALL implement FSM states IDLE, SEND, ALIGN.
REQ-017 Handshake SHALL complete in any cycle with bit_valid=1 and bit_ready=1; bit_ready SHALL equal en AND (one-entry next-bit buffer empty) AND state!=ALIGN.
REQ-018 IDLE: on handshake at cycle t, sw_out SHALL become F0_SEL/F1_SEL per bit_in at t+1, busy=1 at t+1, state SEND, no alignment.
REQ-019 SEND: symbol counter loads SYM_CYC-1 on entry and decrements each cycle; symbol occupies exactly SYM_CYC cycles; sym_strobe=1 when counter=0.
REQ-020 SEND: a handshake SHALL fill the next-bit buffer; a handshake coinciding with counter=0 while the buffer is empty SHALL be used as the next bit (bypass).
REQ-021 At counter=0 with next bit whose select equals current sw_out: SHALL reload counter and stay in SEND, no gap.
REQ-022 At counter=0 with next bit of different select: SHALL enter ALIGN, holding current sw_out.
REQ-023 ALIGN: rising edge on car_in (car_in=1, previous registered car_in=0) or ALIGN_MAX cycles elapsed SHALL load new sw_out next cycle, empty buffer, reload counter, enter SEND; ALIGN cycles are not counted in the symbol.
REQ-024 At counter=0 with no next bit and en=1: SHALL pulse underrun, go IDLE, sw_out=4'b0000 next cycle.
REQ-025 en deasserted mid-symbol: current symbol SHALL complete; at counter=0 SHALL go IDLE, clear buffer, sw_out=0000, no underrun pulse.
REQ-026 en deasserted in ALIGN: SHALL return to IDLE next cycle, sw_out=0000, buffer cleared.
REQ-027 sw_out SHALL always be 4'b0000 or exactly one of F0_SEL/F1_SEL; never multi-hot.

Reset
REQ-028 rst_n low SHALL immediately force state IDLE, sw_out=0000, busy=0, bit_ready=0, sym_strobe=0, underrun=0, counters=0, buffer empty, registered car_in=0.
REQ-029 rst_n low mid-symbol SHALL discard current and buffered bits; first handshake after release behaves per REQ-018.

Verification (SYM_CYC=16, ALIGN_MAX=32)
REQ-030 en=1, one bit 1 handshaken at t -> sw_out=0100 t+1..t+16, sym_strobe at t+16, underrun at t+16, sw_out=0000 at t+17.
REQ-031 Stream 0,0,0 back-to-back -> sw_out=0001 for 48 contiguous cycles, three sym_strobes 16 apart, no ALIGN.
REQ-032 Stream 0,1 with car_in rising 5 cycles after first sym_strobe -> sw_out switches 0001->0100 on the cycle after that edge; second symbol lasts 16 cycles.
REQ-033 Stream 0,1 with car_in held 0 -> switch after exactly 32 ALIGN cycles.
REQ-034 en dropped at cycle 8 of a symbol with buffered bit -> symbol completes, IDLE, sw_out=0000, underrun stays 0, bit_ready=0.
REQ-035 rst_n pulsed low mid-symbol -> all outputs zero asynchronously; subsequent bit 0 gives sw_out=0001 one cycle after handshake.
